// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter core between NUM_REQ byte-stream
// requesters. Ownership is granted round-robin at packet boundaries. Once a
// requester owns the transmitter, it keeps it until its packet ends or it
// stalls too long. Each accepted byte occupies a fixed window of FRAME_TICKS
// baud ticks, because the transmitter gives no completion feedback.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   baud_tick       one-clk pulse at 16x baud, shared with the transmitter
//   req_valid/data/last   per-requester byte stream (byte i in [8i+7:8i])
//   req_ready       per-requester accept (combinational, one-hot or zero)
//   tx_data         byte to the transmitter, stable through the slot
//   tx_start        transmit request, high for START_TICKS ticks
//   grant_id        current or most recent owner
//   grant_valid     a packet lock is held
//   busy            scheduler is not idle
//   timeout_err     one-clk pulse when a stalled lock is dropped
module uart_tx_sched #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_TICKS  = 176,
    parameter int START_TICKS  = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       baud_tick,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_valid,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(FRAME_TICKS + 1);
    localparam int OW  = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [TW-1:0]  START_LAST = TW'(START_TICKS - 1);
    localparam logic [TW-1:0]  FRAME_LAST = TW'(FRAME_TICKS - 1);
    localparam logic [TW-1:0]  FRAME_MAX  = TW'(FRAME_TICKS);
    localparam logic [TW-1:0]  TICK_ONE   = TW'(1);
    localparam logic [OW-1:0]  LOCK_MAX   = OW'(LOCK_TIMEOUT);
    localparam logic [OW-1:0]  LOCK_ONE   = OW'(1);
    // Pointer starts at the top index so that index 0 is searched first.
    localparam logic [IDW-1:0] PTR_INIT   = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        SEND   = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t             state_r, state_n;
    logic [TW-1:0]      tick_cnt_r;
    logic [OW-1:0]      to_cnt_r;
    logic [IDW-1:0]     last_grant_r;
    logic               last_r;
    logic [7:0]         tx_data_r;
    logic               tx_start_r;
    logic [IDW-1:0]     grant_id_r;
    logic               grant_valid_r;
    logic               timeout_err_r;

    logic               rr_found_s;
    logic [IDW-1:0]     rr_pick_s;
    logic [NUM_REQ-1:0] ready_s;
    logic               xfer_s;
    logic [IDW-1:0]     sel_s;
    logic               start_end_s;
    logic               slot_end_s;
    logic               timeout_s;
    logic [7:0]         byte_s;
    int                 cand;

    // Round-robin search: first valid index after the last owner, wrapping.
    always_comb begin
        rr_found_s = 1'b0;
        rr_pick_s  = {IDW{1'b0}};
        cand       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(last_grant_r) + 1 + k) % NUM_REQ;
            if (!rr_found_s && req_valid[cand]) begin
                rr_found_s = 1'b1;
                rr_pick_s  = IDW'(cand);
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Next-state logic plus the per-cycle event strobes used by the datapath.
    always_comb begin
        state_n     = state_r;
        ready_s     = {NUM_REQ{1'b0}};
        xfer_s      = 1'b0;
        sel_s       = grant_id_r;
        start_end_s = 1'b0;
        slot_end_s  = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (rr_found_s) begin
                    ready_s[rr_pick_s] = 1'b1;
                    sel_s              = rr_pick_s;
                    xfer_s             = 1'b1;
                    state_n            = SEND;
                end else begin
                    state_n = IDLE;
                end
            end
            ACCEPT: begin
                // The timeout cycle takes precedence and accepts nothing.
                if (to_cnt_r == LOCK_MAX) begin
                    timeout_s = 1'b1;
                    state_n   = IDLE;
                end else if (req_valid[grant_id_r]) begin
                    ready_s[grant_id_r] = 1'b1;
                    xfer_s              = 1'b1;
                    state_n             = SEND;
                end else begin
                    state_n = ACCEPT;
                end
            end
            SEND: begin
                if (baud_tick && (tick_cnt_r == START_LAST)) begin
                    start_end_s = 1'b1;
                    state_n     = WAIT;
                end else begin
                    state_n = SEND;
                end
            end
            WAIT: begin
                if (baud_tick && (tick_cnt_r == FRAME_LAST)) begin
                    slot_end_s = 1'b1;
                    state_n    = last_r ? IDLE : ACCEPT;
                end else begin
                    state_n = WAIT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign byte_s      = req_data[8*int'(sel_s) +: 8];
    assign req_ready   = rst ? {NUM_REQ{1'b0}} : ready_s;
    assign tx_data     = tx_data_r;
    assign tx_start    = tx_start_r;
    assign grant_id    = grant_id_r;
    assign grant_valid = grant_valid_r;
    assign timeout_err = timeout_err_r;
    assign busy        = (state_r != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Datapath: captured byte, start strobe, lock bookkeeping and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_r     <= 8'h00;
            tx_start_r    <= 1'b0;
            grant_id_r    <= {IDW{1'b0}};
            grant_valid_r <= 1'b0;
            timeout_err_r <= 1'b0;
            last_grant_r  <= PTR_INIT;
            last_r        <= 1'b0;
            tick_cnt_r    <= {TW{1'b0}};
            to_cnt_r      <= {OW{1'b0}};
        end else begin
            timeout_err_r <= timeout_s;
            if (xfer_s) begin
                tx_data_r     <= byte_s;
                tx_start_r    <= 1'b1;
                grant_id_r    <= sel_s;
                grant_valid_r <= 1'b1;
                last_r        <= req_last[sel_s];
                tick_cnt_r    <= {TW{1'b0}};
                to_cnt_r      <= {OW{1'b0}};
            end else begin
                // Ticks on the transfer edge itself are not counted.
                if ((state_r == SEND || state_r == WAIT) && baud_tick &&
                    (tick_cnt_r != FRAME_MAX)) begin
                    tick_cnt_r <= tick_cnt_r + TICK_ONE;
                end
                if (start_end_s) begin
                    tx_start_r <= 1'b0;
                end
                if (slot_end_s) begin
                    if (last_r) begin
                        grant_valid_r <= 1'b0;
                        last_grant_r  <= grant_id_r;
                    end else begin
                        to_cnt_r <= {OW{1'b0}};
                    end
                end else if (state_r == ACCEPT && to_cnt_r != LOCK_MAX) begin
                    to_cnt_r <= to_cnt_r + LOCK_ONE;
                end
                if (timeout_s) begin
                    grant_valid_r <= 1'b0;
                    last_grant_r  <= grant_id_r;
                end
            end
        end
    end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Packet-level scheduler that shares one UART transmitter core between NUM_REQ byte-stream requesters. It arbitrates round-robin at packet boundaries and presents one byte at a time to the transmitter's data/start inputs. It paces bytes by counting baud ticks over a fixed frame window, because the transmitter has no busy/done output. It sits between the message sources (command responders, log streams) and the transmitter core, on the same clk and baud_tick.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- FRAME_TICKS, 176: baud ticks per byte slot. 10 bits x 16 ticks, plus 16 ticks of alignment margin.
- START_TICKS, 16: baud ticks that tx_start is held high; the transmitter samples start once per 16 ticks.
- LOCK_TIMEOUT, 4096: clk cycles a locked owner may leave its next byte missing before the lock is forcibly released.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- baud_tick  in  1  one-clk pulse at 16x baud rate, shared with the transmitter.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  byte i in bits [8i+7:8i].
- req_last  in  NUM_REQ  the byte is the final byte of its packet.
- req_ready  out  NUM_REQ  per-requester accept; combinational, at most one bit high.
- tx_data  out  8  byte to the transmitter; registered, stable for the whole slot.
- tx_start  out  1  transmit request to the transmitter; registered.
- grant_id  out  clog2(NUM_REQ)  current or last owner index.
- grant_valid  out  1  a packet lock is held.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-clk pulse when a lock is released by timeout.

## Operation
- States:
  - IDLE: no owner.
  - ACCEPT: owner chosen, waiting for its byte.
  - SEND: tx_start high.
  - WAIT: remainder of the byte slot.
- Reset: state IDLE, all outputs 0, round-robin pointer so that index 0 has highest priority, tick and timeout counters cleared.
- IDLE: if any req_valid is set, select the first valid index searching from (last_grant+1) mod NUM_REQ upward, wrapping. Set req_ready for that index in the same cycle. The transfer occurs on that edge.
- Transfer (valid & ready at an edge):
  - tx_data <= byte; tx_start <= 1; grant_id <= idx; grant_valid <= 1.
  - Tick counter cleared; go to SEND.
  - Record whether req_last was set.
- SEND: count baud_tick. On the cycle the count reaches START_TICKS, tx_start <= 0 at that edge and go to WAIT.
- WAIT: keep counting. When the count reaches FRAME_TICKS:
  - If the recorded byte was last: grant_valid <= 0, last_grant <= grant_id, go to IDLE.
  - Otherwise go to ACCEPT.
- ACCEPT: only the owner's req_ready may be high, and it equals the owner's req_valid. A transfer behaves exactly as in IDLE. Other requesters are ignored, even if valid.
- Timeout: in ACCEPT, a timeout counter increments every clk. It clears on every transfer. On reaching LOCK_TIMEOUT:
  - timeout_err pulses, grant_valid <= 0, last_grant <= grant_id, go to IDLE.
  - No byte is sent in that cycle.
- tx_data holds its value after a slot ends, until the next transfer.
- grant_id holds the last owner while grant_valid=0.
- Counter widths must hold FRAME_TICKS and LOCK_TIMEOUT without wrap. Counters saturate at their terminal value; they never wrap.
- rst asserted mid-slot aborts immediately: all outputs return to reset values on the next edge, including tx_start=0. The pointer is reset. No ready is issued during reset.

## Timing
- Acceptance latency: req_ready is high in the same cycle as req_valid when state is IDLE or ACCEPT with a matching owner. There is no bubble.
- tx_start rises 1 clk after the transfer edge. It stays high through exactly START_TICKS baud ticks.
- Byte slot: from the transfer edge until the FRAME_TICKS-th baud_tick counted, inclusive. The next transfer can occur in the cycle after that tick.
- baud_tick on the transfer edge itself is not counted. Counting starts in the first SEND cycle.
- Simultaneous requests in IDLE: exactly one grant, per the round-robin order. The losers keep req_ready=0.
- An owner that drops valid in ACCEPT keeps the lock until the timeout.
- Single-byte packet (req_last=1 on the first byte): release at the end of that slot. The pointer advances past the owner.

## Test plan
- Reset: hold rst with all req_valid=1 -> req_ready=0, tx_start=0, tx_data=0x00, busy=0, grant_valid=0.
- Single byte: req0 sends 0x55 with last=1 -> req_ready[0] high for 1 clk. Next clk: tx_data=0x55, tx_start=1. tx_start stays high for 16 ticks. busy clears after 176 ticks. grant_valid=0.
- Packet lock: req1 sends 0xA1, 0xA2, 0xA3 (last on 0xA3) while req2 is constantly valid -> the three bytes go out in consecutive slots, req_ready[2] stays 0, and req2 is granted next.
- Round-robin: all four requesters valid with single-byte packets -> grant order 0, 1, 2, 3, 0, exactly 176 baud ticks apart.
- Timeout: req3 sends one byte with last=0, then drops valid -> after the slot plus LOCK_TIMEOUT clk: timeout_err pulses once, grant_valid=0, and req0 is the next grant when valid.
- Mid-slot reset: assert rst at tick 8 of SEND -> tx_start=0 on the next edge, state IDLE. After release, req0 is the highest priority.
